// File: rtl/execute_unit.sv
// Execute stage: single-cycle ALU ops plus iterative 32-step MULT/DIV into HI/LO,
// with an en/alu_done handshake driven by the control FSM.
module execute_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [4:0]       alu_ctrl,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic [4:0]       shamt,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             alu_done
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, EXEC, MULDIV, DONE} state_t;

    state_t             state, state_next;
    logic [4:0]         op_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [4:0]         sh_q;
    logic               setup;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mag_m;
    logic               neg_q, neg_r;

    logic [WIDTH-1:0]   alu_res, sum, diff;
    logic               alu_ovf;
    logic               md_signed, md_div, last;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     add_m, r_sh, sub_d;
    logic [2*WIDTH-1:0] step, prod;
    logic [WIDTH-1:0]   hi_new, lo_new;

    assign busy     = (state != IDLE);
    assign alu_done = (state == DONE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (en) state_next = (alu_ctrl[4:2] == 3'b100) ? MULDIV : EXEC;
            EXEC:    state_next = DONE;
            MULDIV:  if (!setup && last) state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        sum     = a_q + b_q;
        diff    = a_q - b_q;
        case (op_q)
            5'd0:  alu_res = a_q & b_q;
            5'd1:  alu_res = a_q | b_q;
            5'd2: begin
                alu_res = sum;
                alu_ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            5'd3:  alu_res = sum;
            5'd4: begin
                alu_res = diff;
                alu_ovf = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
            end
            5'd5:  alu_res = diff;
            5'd6:  alu_res = {{(WIDTH-1){1'b0}}, $signed(a_q) < $signed(b_q)};
            5'd7:  alu_res = {{(WIDTH-1){1'b0}}, a_q < b_q};
            5'd8:  alu_res = ~(a_q | b_q);
            5'd9:  alu_res = a_q ^ b_q;
            5'd10: alu_res = b_q << sh_q;
            5'd11: alu_res = b_q >> sh_q;
            5'd12: alu_res = $signed(b_q) >>> sh_q;
            5'd13: alu_res = b_q << 16;
            5'd14: alu_res = hi;
            5'd15: alu_res = lo;
            default: ;
        endcase
    end

    // Iterative datapath works on magnitudes; signs are reapplied when HI/LO are written.
    always_comb begin
        md_signed = ~op_q[0];
        md_div    = op_q[1];
        last      = (cnt == CW'(WIDTH - 1));
        mag_a     = (md_signed && a_q[WIDTH-1]) ? -a_q : a_q;
        mag_b     = (md_signed && b_q[WIDTH-1]) ? -b_q : b_q;
        add_m     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_m} : '0);
        r_sh      = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        sub_d     = r_sh - {1'b0, mag_m};
        if (!md_div)
            step = {add_m, acc[WIDTH-1:1]};
        else if (!sub_d[WIDTH])
            step = {sub_d[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        else
            step = {r_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        prod   = neg_q ? -step : step;
        hi_new = prod[2*WIDTH-1:WIDTH];
        lo_new = prod[WIDTH-1:0];
        if (md_div) begin
            if (b_q == '0) begin
                lo_new = '1;
                hi_new = a_q;
            end else begin
                lo_new = neg_q ? -step[WIDTH-1:0] : step[WIDTH-1:0];
                hi_new = neg_r ? -step[2*WIDTH-1:WIDTH] : step[2*WIDTH-1:WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            sh_q     <= '0;
            setup    <= 1'b0;
            cnt      <= '0;
            acc      <= '0;
            mag_m    <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result   <= '0;
            zero     <= 1'b0;
            overflow <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            case (state)
                IDLE: if (en) begin
                    op_q  <= alu_ctrl;
                    a_q   <= operand_a;
                    b_q   <= operand_b;
                    sh_q  <= shamt;
                    setup <= 1'b1;
                end
                EXEC: begin
                    result   <= alu_res;
                    zero     <= (alu_res == '0) && (op_q < 5'd20);
                    overflow <= alu_ovf;
                end
                MULDIV: if (setup) begin
                    setup <= 1'b0;
                    cnt   <= '0;
                    mag_m <= md_div ? mag_b : mag_a;
                    acc   <= {{WIDTH{1'b0}}, (md_div ? mag_a : mag_b)};
                    neg_q <= md_signed && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                    neg_r <= md_signed && a_q[WIDTH-1];
                end else begin
                    acc <= step;
                    cnt <= cnt + CW'(1);
                    if (last) begin
                        hi       <= hi_new;
                        lo       <= lo_new;
                        result   <= lo_new;
                        zero     <= (lo_new == '0);
                        overflow <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_execute_unit.sv
// Bench for execute_unit: vector table through a scoreboard queue, plus
// hand-written re-trigger and mid-divide reset sequences.
module tb_execute_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [4:0]  alu_ctrl = '0;
    logic [31:0] operand_a = '0;
    logic [31:0] operand_b = '0;
    logic [4:0]  shamt = '0;
    logic [31:0] result, hi, lo;
    logic        zero, overflow, busy, alu_done;

    execute_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .alu_ctrl(alu_ctrl),
        .operand_a(operand_a), .operand_b(operand_b), .shamt(shamt),
        .result(result), .zero(zero), .overflow(overflow),
        .hi(hi), .lo(lo), .busy(busy), .alu_done(alu_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [4:0]  op;
        logic [31:0] a, b;
        logic [4:0]  sh;
        logic [31:0] res;
        logic        z, ov;
        logic [31:0] hi, lo;
        int          lat;
    } vec_t;

    vec_t exp_q[$];
    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input string nm, input logic [4:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic [4:0] sh, input logic [31:0] res,
                                input logic z, input logic ov, input logic [31:0] h,
                                input logic [31:0] l, input int lat);
        vec_t v;
        v.name = nm; v.op = op; v.a = a; v.b = b; v.sh = sh; v.res = res;
        v.z = z; v.ov = ov; v.hi = h; v.lo = l; v.lat = lat;
        return v;
    endfunction

    // Scoreboard: every alu_done pops one expected record.
    always @(negedge clk) begin : monitor
        vec_t e;
        if (rst_n && alu_done) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got alu_done=1 expected no completion");
            end else begin
                e = exp_q.pop_front();
                chk({e.name, "_result"}, result, e.res);
                chk({e.name, "_zero"}, {31'b0, zero}, {31'b0, e.z});
                chk({e.name, "_overflow"}, {31'b0, overflow}, {31'b0, e.ov});
                chk({e.name, "_hi"}, hi, e.hi);
                chk({e.name, "_lo"}, lo, e.lo);
            end
        end
    end

    task automatic start_op(input vec_t v);
        @(negedge clk);
        alu_ctrl = v.op; operand_a = v.a; operand_b = v.b; shamt = v.sh; en = 1'b1;
        exp_q.push_back(v);
        @(posedge clk);
        @(negedge clk);
        en = 1'b0;
        operand_a = $urandom; operand_b = $urandom; shamt = 5'($urandom);
        alu_ctrl = 5'($urandom_range(0, 15));
    endtask

    task automatic run_op(input vec_t v);
        int k, busy_n;
        bit got;
        start_op(v);
        k = 1; busy_n = 0; got = 1'b0;
        while (k <= 100 && !got) begin
            if (alu_done) got = 1'b1;
            else begin
                if (busy) busy_n++;
                @(negedge clk);
                k++;
            end
        end
        if (!got && exp_q.size() > 0) void'(exp_q.pop_back());
        chk({v.name, "_latency"}, k, v.lat);
        chk({v.name, "_busy_cycles"}, busy_n, v.lat - 1);
        @(negedge clk);
        chk({v.name, "_done_pulse"}, {31'b0, alu_done}, 32'd0);
    endtask

    initial begin
        int dones, first;
        vecs.push_back(mk("add_ovf", 5'd2, 32'h7FFFFFFF, 32'h1, 0, 32'h80000000, 0, 1, 0, 0, 2));
        vecs.push_back(mk("subu_zero", 5'd5, 32'd5, 32'd5, 0, 32'h0, 1, 0, 0, 0, 2));
        vecs.push_back(mk("sra", 5'd12, 32'h0, 32'h80000000, 4, 32'hF8000000, 0, 0, 0, 0, 2));
        vecs.push_back(mk("sltu", 5'd7, 32'h1, 32'hFFFFFFFF, 0, 32'h1, 0, 0, 0, 0, 2));
        vecs.push_back(mk("slt", 5'd6, 32'h1, 32'hFFFFFFFF, 0, 32'h0, 1, 0, 0, 0, 2));
        vecs.push_back(mk("and", 5'd0, 32'hF0F0F0F0, 32'hFF00FF00, 0, 32'hF000F000, 0, 0, 0, 0, 2));
        vecs.push_back(mk("or", 5'd1, 32'hF0F0F0F0, 32'hFF00FF00, 0, 32'hFFF0FFF0, 0, 0, 0, 0, 2));
        vecs.push_back(mk("nor", 5'd8, 32'hF0F0F0F0, 32'hFF00FF00, 0, 32'h000F000F, 0, 0, 0, 0, 2));
        vecs.push_back(mk("xor", 5'd9, 32'hF0F0F0F0, 32'hFF00FF00, 0, 32'h0FF00FF0, 0, 0, 0, 0, 2));
        vecs.push_back(mk("sub_ovf", 5'd4, 32'h80000000, 32'h1, 0, 32'h7FFFFFFF, 0, 1, 0, 0, 2));
        vecs.push_back(mk("addu_noflag", 5'd3, 32'h7FFFFFFF, 32'h1, 0, 32'h80000000, 0, 0, 0, 0, 2));
        vecs.push_back(mk("sll31", 5'd10, 32'h0, 32'h1, 31, 32'h80000000, 0, 0, 0, 0, 2));
        vecs.push_back(mk("srl", 5'd11, 32'h0, 32'h80000000, 4, 32'h08000000, 0, 0, 0, 0, 2));
        vecs.push_back(mk("lui", 5'd13, 32'h0, 32'h1234ABCD, 0, 32'hABCD0000, 0, 0, 0, 0, 2));
        vecs.push_back(mk("mult_neg", 5'd16, 32'hFFFFFFFD, 32'd5, 0, 32'hFFFFFFF1, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFF1, 34));
        vecs.push_back(mk("mfhi", 5'd14, 32'h0, 32'h0, 0, 32'hFFFFFFFF, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFF1, 2));
        vecs.push_back(mk("multu_max", 5'd17, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'h1, 0, 0, 32'hFFFFFFFE, 32'h1, 34));
        vecs.push_back(mk("mflo", 5'd15, 32'h0, 32'h0, 0, 32'h1, 0, 0, 32'hFFFFFFFE, 32'h1, 2));
        vecs.push_back(mk("div_neg", 5'd18, 32'hFFFFFFF9, 32'd2, 0, 32'hFFFFFFFD, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFD, 34));
        vecs.push_back(mk("divu_by0", 5'd19, 32'd9, 32'd0, 0, 32'hFFFFFFFF, 0, 0, 32'd9, 32'hFFFFFFFF, 34));
        vecs.push_back(mk("div_minint", 5'd18, 32'h80000000, 32'hFFFFFFFF, 0, 32'h80000000, 0, 0, 32'h0, 32'h80000000, 34));
        vecs.push_back(mk("mult_2p32", 5'd16, 32'h10000, 32'h10000, 0, 32'h0, 1, 0, 32'h1, 32'h0, 34));
        vecs.push_back(mk("divu_rem", 5'd19, 32'd100, 32'd7, 0, 32'd14, 0, 0, 32'd2, 32'd14, 34));
        vecs.push_back(mk("div_negdivisor", 5'd18, 32'd7, 32'hFFFFFFFE, 0, 32'hFFFFFFFD, 0, 0, 32'd1, 32'hFFFFFFFD, 34));

        repeat (3) @(negedge clk);
        chk("rst_result", result, 0);
        chk("rst_flags", {29'b0, zero, overflow, alu_done}, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        rst_n = 1'b1;

        foreach (vecs[i]) run_op(vecs[i]);

        // en pulsed mid-MULT must be ignored: exactly one completion, on cycle 34.
        start_op(mk("mult_repulse", 5'd16, 32'd6, 32'd7, 0, 32'd42, 0, 0, 32'd0, 32'd42, 34));
        dones = 0; first = 0;
        for (int k = 1; k <= 60; k++) begin
            if (k == 10) begin en = 1'b1; alu_ctrl = 5'd2; end
            if (k == 11) en = 1'b0;
            if (alu_done) begin
                dones++;
                if (first == 0) first = k;
            end
            @(negedge clk);
        end
        chk("repulse_done_count", dones, 1);
        chk("repulse_done_cycle", first, 34);

        // Reset at iteration 10 of a MULT aborts it with no completion.
        start_op(mk("mult_aborted", 5'd16, 32'hFFFFFFFD, 32'd5, 0, 32'hFFFFFFF1, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFF1, 34));
        repeat (11) @(negedge clk);
        chk("abort_busy_before", {31'b0, busy}, 1);
        rst_n = 1'b0;
        #1;
        void'(exp_q.pop_back());
        chk("abort_result", result, 0);
        chk("abort_hi", hi, 0);
        chk("abort_lo", lo, 0);
        chk("abort_flags", {29'b0, zero, overflow, alu_done}, 0);
        chk("abort_busy", {31'b0, busy}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int k = 0; k < 40; k++) begin
            if (alu_done) dones++;
            @(negedge clk);
        end
        chk("abort_no_done", dones, 0);
        run_op(mk("mflo_after_rst", 5'd15, 32'h0, 32'h0, 0, 32'h0, 1, 0, 32'h0, 32'h0, 2));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        n_cmp++;
        n_bad++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
